fuzzy_pwm_ctrl_pipe: RTL and testbench

//  Parametrised, pipelined successor of the fixed 8-bit fuzzy duty controller.
//  - Fuzzifies a crisp sample onto 2^SEL_W+1 evenly spaced triangular sets.
//  - Infers from a run-time writable rule table of output singletons.
//  - Defuzzifies by two-set weighted average and drives an internal PWM generator.
//  - Sits between digitization and the power stage; valid/ready on both sample sides.

---
 rtl/fuzzy_pwm_ctrl_pipe_pkg.sv | 31 +++
 rtl/fuzzy_pwm_ctrl_pipe_pwm_gen.sv | 59 +++++
 rtl/fuzzy_pwm_ctrl_pipe.sv | 142 ++++++++++++++
 tb/tb_fuzzy_pwm_ctrl_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pwm_ctrl_pipe_pkg.sv
// Shared constants and helpers for the pipelined fuzzy duty controller.
package fuzzy_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEL_W  = 3;
    localparam int DEF_DUTY_W = 8;

    // Duty word at the default width, handy for benches and tooling.
    typedef logic [DEF_DUTY_W-1:0] duty_t;

    // Number of triangular sets: 2^sel_w intervals need 2^sel_w+1 peaks.
    function automatic int nsets(input int sel_w);
        return (1 << sel_w) + 1;
    endfunction

    // Spacing between neighbouring set peaks on the crisp axis.
    function automatic int step(input int data_w, input int sel_w);
        return 1 << (data_w - sel_w);
    endfunction

    // Linear default singleton for set k, clipped to full scale on the last set.
    function automatic int default_rule(input int k, input int duty_w, input int sel_w);
        int v;
        v = k << (duty_w - sel_w);
        if (v > (1 << duty_w) - 1) begin
            v = (1 << duty_w) - 1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fuzzy_pwm_ctrl_pipe_pwm_gen.sv
// PWM generator: free-running counter, duty staged as pending then active so a
// new duty only takes effect at the start of a period.
module fz_pwm_gen #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_pwm
);

    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_pending;
    logic [DUTY_W-1:0] r_active;
    logic              r_pwm;
    logic              w_wrap;

    // Counter is at its last value, so the next edge starts a new period.
    assign w_wrap = (r_cnt == {DUTY_W{1'b1}});
    assign o_pwm  = r_pwm;

    // Period counter, wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Capture every delivered duty result; the latest one wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (i_load) begin
            r_pending <= i_duty;
        end
    end

    // Promote pending duty only on the wrap edge to avoid mid-period glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
        end else if (w_wrap) begin
            r_active <= r_pending;
        end
    end

    // Registered compare; duty 0 never goes high, full scale drops one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < r_active);
        end
    end

endmodule

// File: rtl/fuzzy_pwm_ctrl_pipe.sv
// Pipelined fuzzy duty controller: fuzzify onto evenly spaced triangular sets,
// weight two neighbouring rule singletons, and feed the result to a PWM.
//
// Handshake: a transfer happens on a side when valid and ready are both high
// at a rising edge. valid, once raised, holds with stable data until accepted.
// Here advance = !out_valid | out_ready moves all three stages together and
// in_ready = advance combinationally, so a stalled pipe holds every stage.
module fuzzy_pwm_ctrl_pipe
    import fuzzy_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rule_we,
    input  logic [SEL_W:0]    rule_addr,
    input  logic [DUTY_W-1:0] rule_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DUTY_W-1:0] out_duty,
    output logic              pwm_out
);

    localparam int NSETS  = nsets(SEL_W);
    localparam int FRAC_W = DATA_W - SEL_W;
    localparam int PROD_W = DUTY_W + FRAC_W;
    localparam int SUM_W  = PROD_W + 1;

    logic              w_advance;
    logic              w_out_fire;

    logic              r_s1_valid;
    logic [SEL_W-1:0]  r_s1_i;
    logic [FRAC_W-1:0] r_s1_f;

    logic              r_s2_valid;
    logic [PROD_W-1:0] r_s2_p0;
    logic [PROD_W-1:0] r_s2_p1;

    logic              r_out_valid;
    logic [DUTY_W-1:0] r_out_duty;

    logic [DUTY_W-1:0] r_table [NSETS];

    logic [SEL_W:0]    w_idx0;
    logic [SEL_W:0]    w_idx1;
    logic [PROD_W-1:0] w_c0;
    logic [PROD_W-1:0] w_c1;
    logic [PROD_W-1:0] w_f;
    logic [PROD_W-1:0] w_p0;
    logic [PROD_W-1:0] w_p1;
    logic [SUM_W-1:0]  w_sum;
    logic [SUM_W-1:0]  w_quot;

    assign w_advance  = !r_out_valid || out_ready;
    assign in_ready   = w_advance;
    assign w_out_fire = r_out_valid && out_ready;
    assign out_valid  = r_out_valid;
    assign out_duty   = r_out_duty;

    // Segment index i selects sets i and i+1; i never exceeds NSETS-2.
    assign w_idx0 = {1'b0, r_s1_i};
    assign w_idx1 = w_idx0 + 1'b1;
    assign w_c0   = PROD_W'(r_table[w_idx0]);
    assign w_c1   = PROD_W'(r_table[w_idx1]);
    assign w_f    = PROD_W'(r_s1_f);
    // c0*(STEP-f) written as c0*STEP - c0*f keeps every term inside PROD_W.
    assign w_p0   = (w_c0 << FRAC_W) - (w_c0 * w_f);
    assign w_p1   = w_c1 * w_f;
    assign w_sum  = SUM_W'(r_s2_p0) + SUM_W'(r_s2_p1);
    assign w_quot = w_sum >> FRAC_W;

    // Rule table: reset to the linear default, writes to addresses past the last set are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSETS; k++) begin
                r_table[k] <= DUTY_W'(default_rule(k, DUTY_W, SEL_W));
            end
        end else if (rule_we && (int'(rule_addr) < NSETS)) begin
            r_table[rule_addr] <= rule_wdata;
        end
    end

    // Stage 1: split the crisp sample into segment index and fraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_f     <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_i <= in_data[DATA_W-1 -: SEL_W];
                r_s1_f <= in_data[FRAC_W-1:0];
            end
        end
    end

    // Stage 2: read both singletons (pre-edge table contents) and weight them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_p0    <= '0;
            r_s2_p1    <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_p0 <= w_p0;
                r_s2_p1 <= w_p1;
            end
        end
    end

    // Stage 3: sum and normalise by STEP; result held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_duty  <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_duty <= DUTY_W'(w_quot);
            end
        end
    end

    fz_pwm_gen #(
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_out_fire),
        .i_duty (r_out_duty),
        .o_pwm  (pwm_out)
    );

endmodule

// File: tb/tb_fuzzy_pwm_ctrl_pipe.sv
// Directed bench for the pipelined fuzzy duty controller.
module tb_fuzzy_pwm_ctrl_pipe;
    import fuzzy_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       rule_we;
    logic [3:0] rule_addr;
    logic [7:0] rule_wdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_duty;
    logic       pwm_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the PWM period counter (counts edges since reset).
    logic [7:0] m_cnt;

    duty_t exp_q[$];

    fuzzy_pwm_ctrl_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rule_we    (rule_we),
        .rule_addr  (rule_addr),
        .rule_wdata (rule_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_duty   (out_duty),
        .pwm_out    (pwm_out)
    );

    // Clock and counter model.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 8'd0;
        else        m_cnt <= m_cnt + 8'd1;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_sample(input logic [7:0] x);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic write_rule(input logic [3:0] a, input logic [7:0] d);
        rule_we    = 1'b1;
        rule_addr  = a;
        rule_wdata = d;
        @(posedge clk); #1;
        rule_we = 1'b0;
    endtask

    // One aligned PWM period; fires fire_x so its result lands around cnt 100.
    task automatic pwm_period(input logic [7:0] fire_x, output int hi,
                              output int got_duty, output int n_fire);
        hi = 0; got_duty = -1; n_fire = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            if (pwm_out) hi++;
            if (out_valid) begin
                n_fire++;
                got_duty = int'(out_duty);
            end
            if (m_cnt == 8'd97) begin
                in_valid = 1'b1;
                in_data  = fire_x;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_duty !== 8'd0) begin n_fail++; $display("FAIL reset_out_duty: got %0d expected 0", out_duty); end
        n_tests++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        #10 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL post_reset_pwm: got %b expected 0", pwm_out); end
    endtask

    task automatic test_defaults();
        logic [7:0] xs [4];
        logic [7:0] es [4];
        int n;
        xs[0] = 8'h00; es[0] = 8'd0;
        xs[1] = 8'h50; es[1] = 8'd80;
        xs[2] = 8'hFF; es[2] = 8'd254;
        xs[3] = 8'hE0; es[3] = 8'd224;
        for (int v = 0; v < 4; v++) begin
            drive_sample(xs[v]);
            wait_out(n);
            n_tests++; if (n !== 2) begin n_fail++; $display("FAIL defaults_latency x=%0h: got %0d expected 2 extra edges", xs[v], n); end
            n_tests++; if (out_duty !== es[v]) begin n_fail++; $display("FAIL defaults_duty x=%0h: got %0d expected %0d", xs[v], out_duty, es[v]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs [5];
        logic [7:0] es [5];
        logic       ev;
        xs[0] = 8'h08; es[0] = 8'd8;
        xs[1] = 8'h18; es[1] = 8'd24;
        xs[2] = 8'h28; es[2] = 8'd40;
        xs[3] = 8'h38; es[3] = 8'd56;
        xs[4] = 8'h48; es[4] = 8'd72;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = xs[0];
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk); #1;
            ev = (j >= 3 && j <= 7);
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL b2b_valid cycle %0d: got %b expected %b", j, out_valid, ev); end
            if (ev) begin
                n_tests++; if (out_duty !== es[j-3]) begin n_fail++; $display("FAIL b2b_duty cycle %0d: got %0d expected %0d", j, out_duty, es[j-3]); end
            end
            if (j < 5) in_data = xs[j];
            else       in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] xs [4];
        int idx;
        int got;
        int guard;
        duty_t e;
        xs[0] = 8'h10; xs[1] = 8'h20; xs[2] = 8'h30; xs[3] = 8'h40;
        exp_q.delete();
        idx = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = xs[0];
        for (int c = 1; c <= 6; c++) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(duty_t'(in_data));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) in_data = xs[idx];
            else         in_valid = 1'b0;
            if (c >= 3) begin
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready); end
                n_tests++; if (out_duty !== 8'd16 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold cycle %0d: got valid=%b duty=%0d expected valid=1 duty=16", c, out_valid, out_duty); end
            end
        end
        n_tests++; if (idx !== 3) begin n_fail++; $display("FAIL bp_held_count: got %0d expected 3", idx); end
        out_ready = 1'b1;
        got = 0;
        guard = 0;
        while (got < 4 && guard < 12) begin
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_tests++; if (out_duty !== e) begin n_fail++; $display("FAIL bp_order #%0d: got %0d expected %0d", got, out_duty, e); end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(duty_t'(in_data));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) in_data = xs[idx];
            else         in_valid = 1'b0;
            guard++;
        end
        n_tests++; if (got !== 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 4", got); end
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_leftover: got %0d expected 0", exp_q.size()); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_pwm();
        int n;
        int wraps;
        int hi;
        int gd;
        int nf;
        out_ready = 1'b1;
        write_rule(4'd7, 8'd255);
        drive_sample(8'h40);
        wait_out(n);
        n_tests++; if (out_duty !== 8'd64) begin n_fail++; $display("FAIL pwm_setup_duty: got %0d expected 64", out_duty); end
        wraps = 0; n = 0;
        while (wraps < 2 && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (m_cnt == 8'd0) wraps++;
        end
        n_tests++; if (wraps !== 2) begin n_fail++; $display("FAIL pwm_align: got %0d wraps expected 2", wraps); end
        pwm_period(8'hC0, hi, gd, nf);
        n_tests++; if (hi !== 64) begin n_fail++; $display("FAIL pwm_duty64_high: got %0d expected 64", hi); end
        n_tests++; if (gd !== 192 || nf !== 1) begin n_fail++; $display("FAIL pwm_fire192: got duty %0d fires %0d expected 192 x1", gd, nf); end
        pwm_period(8'hE0, hi, gd, nf);
        n_tests++; if (hi !== 192) begin n_fail++; $display("FAIL pwm_duty192_high: got %0d expected 192", hi); end
        n_tests++; if (gd !== 255) begin n_fail++; $display("FAIL pwm_fire255: got %0d expected 255", gd); end
        pwm_period(8'h00, hi, gd, nf);
        n_tests++; if (hi !== 255) begin n_fail++; $display("FAIL pwm_duty255_high: got %0d expected 255", hi); end
        n_tests++; if (gd !== 0) begin n_fail++; $display("FAIL pwm_fire0: got %0d expected 0", gd); end
        write_rule(4'd7, 8'd224);
    endtask

    task automatic test_rule_write();
        logic [7:0] xs [3];
        logic [7:0] es [3];
        int n;
        out_ready = 1'b1;
        write_rule(4'd2, 8'd200);
        write_rule(4'd9, 8'd7);
        write_rule(4'd15, 8'd7);
        xs[0] = 8'h40; es[0] = 8'd200;
        xs[1] = 8'h20; es[1] = 8'd32;
        xs[2] = 8'hFF; es[2] = 8'd254;
        for (int v = 0; v < 3; v++) begin
            drive_sample(xs[v]);
            wait_out(n);
            n_tests++; if (out_duty !== es[v] || n !== 2) begin n_fail++; $display("FAIL rule_duty x=%0h: got %0d (lat %0d) expected %0d", xs[v], out_duty, n, es[v]); end
            @(posedge clk); #1;
        end
        // Write lands on the same edge the in-flight sample enters stage 2.
        write_rule(4'd2, 8'd64);
        drive_sample(8'h40);
        rule_we = 1'b1; rule_addr = 4'd2; rule_wdata = 8'd200;
        @(posedge clk); #1;
        rule_we = 1'b0;
        in_valid = 1'b1; in_data = 8'h40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_duty !== 8'd64) begin n_fail++; $display("FAIL rule_race_old: got valid=%b duty=%0d expected valid=1 duty=64", out_valid, out_duty); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rule_race_gap: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b1 || out_duty !== 8'd200) begin n_fail++; $display("FAIL rule_race_new: got valid=%b duty=%0d expected valid=1 duty=200", out_valid, out_duty); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int stale;
        int hi;
        int n;
        out_ready = 1'b1;
        write_rule(4'd2, 8'd123);
        in_valid = 1'b1; in_data = 8'h50;
        repeat (4) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_stream_valid: got %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_duty !== 8'd0 || pwm_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: got valid=%b duty=%0d pwm=%b expected 0 0 0", out_valid, out_duty, pwm_out); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0; hi = 0;
        for (int k = 0; k < 260; k++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
            if (pwm_out) hi++;
        end
        n_tests++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale_valid: got %0d expected 0", stale); end
        n_tests++; if (hi !== 0) begin n_fail++; $display("FAIL mid_duty0_pwm: got %0d high expected 0", hi); end
        drive_sample(8'h40);
        wait_out(n);
        n_tests++; if (out_duty !== 8'd64 || n !== 2) begin n_fail++; $display("FAIL mid_table_default: got %0d (lat %0d) expected 64", out_duty, n); end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        rule_we    = 1'b0;
        rule_addr  = 4'd0;
        rule_wdata = 8'd0;
        out_ready  = 1'b1;
        test_reset();
        test_defaults();
        test_back_to_back();
        test_backpressure();
        test_pwm();
        test_rule_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
